// File: rtl/pipe_if2id.sv
// ---------------------------------------------------------------------------
// pipe_if2id
//
// IF/ID pipeline boundary for the MIPS core. It registers the fetched
// instruction word and its PC+4 for decode. When decode stalls it holds its
// contents. On a control-flow flush it turns them into a NOP bubble.
//
// A one-entry skid register catches the word that instruction memory returns
// in the same cycle a stall begins. Because if_ready is registered, fetch only
// learns about the stall one cycle late, and without the skid entry that word
// would be lost.
//
// Optional feature (compile-time macro PIPE_IF2ID_STATCNT_EN):
//   Adds the stallcnt output. It is a saturating count of the edges at which a
//   valid word was held because of id_stall. Only reset clears it.
//
// Parameters:
//   NOP_INSTR   word shown on id_instr whenever no valid instruction is held
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-low reset
//   if_instr    fetched instruction word
//   if_pcplus4  PC+4 of if_instr
//   if_valid    if_instr / if_pcplus4 are valid this cycle
//   if_ready    registered; stage accepts a word this cycle
//   id_stall    decode cannot consume the current word
//   flush       squash all held and incoming words
//   id_instr    registered instruction word to decode
//   id_pcplus4  registered PC+4 to decode
//   id_valid    registered; id_instr is a real instruction
//   stallcnt    stall statistics counter (PIPE_IF2ID_STATCNT_EN only)
// ---------------------------------------------------------------------------
module pipe_if2id #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pcplus4,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic        id_stall,
    input  logic        flush,
    output logic [31:0] id_instr,
    output logic [31:0] id_pcplus4,
`ifdef PIPE_IF2ID_STATCNT_EN
    output logic        id_valid,
    output logic [31:0] stallcnt
`else
    output logic        id_valid
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_SKID
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] main_instr_q, main_instr_d;
    logic [31:0] main_pcplus4_q, main_pcplus4_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pcplus4_q, skid_pcplus4_d;
    logic        id_valid_q, id_valid_d;
    logic        if_ready_q, if_ready_d;

    logic accept;
    logic consume;

    assign accept  = if_valid && if_ready_q;
    assign consume = id_valid_q && !id_stall;

    // Occupancy FSM and datapath steering. When the main register empties it
    // is loaded with the bubble pattern, so the outputs never need masking.
    always_comb begin
        state_d        = state_q;
        main_instr_d   = main_instr_q;
        main_pcplus4_d = main_pcplus4_q;
        skid_instr_d   = skid_instr_q;
        skid_pcplus4_d = skid_pcplus4_q;
        id_valid_d     = id_valid_q;

        if (flush) begin
            state_d        = ST_EMPTY;
            main_instr_d   = NOP_INSTR;
            main_pcplus4_d = 32'h0;
            id_valid_d     = 1'b0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d        = ST_FULL;
                        main_instr_d   = if_instr;
                        main_pcplus4_d = if_pcplus4;
                        id_valid_d     = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (consume && accept) begin
                        main_instr_d   = if_instr;
                        main_pcplus4_d = if_pcplus4;
                    end else if (consume) begin
                        state_d        = ST_EMPTY;
                        main_instr_d   = NOP_INSTR;
                        main_pcplus4_d = 32'h0;
                        id_valid_d     = 1'b0;
                    end else if (accept) begin
                        state_d        = ST_SKID;
                        skid_instr_d   = if_instr;
                        skid_pcplus4_d = if_pcplus4;
                    end
                end
                ST_SKID: begin
                    // if_ready is low here, so only the skid word can move up
                    if (consume) begin
                        state_d        = ST_FULL;
                        main_instr_d   = skid_instr_q;
                        main_pcplus4_d = skid_pcplus4_q;
                    end
                end
                default: begin
                    state_d        = ST_EMPTY;
                    main_instr_d   = NOP_INSTR;
                    main_pcplus4_d = 32'h0;
                    id_valid_d     = 1'b0;
                end
            endcase
        end

        if_ready_d = (state_d != ST_SKID);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_EMPTY;
            main_instr_q   <= NOP_INSTR;
            main_pcplus4_q <= 32'h0;
            id_valid_q     <= 1'b0;
            if_ready_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            main_instr_q   <= main_instr_d;
            main_pcplus4_q <= main_pcplus4_d;
            id_valid_q     <= id_valid_d;
            if_ready_q     <= if_ready_d;
        end
    end

    // The skid contents only matter while in SKID, so they are not reset
    always_ff @(posedge clk) begin
        skid_instr_q   <= skid_instr_d;
        skid_pcplus4_q <= skid_pcplus4_d;
    end

    assign id_instr   = main_instr_q;
    assign id_pcplus4 = main_pcplus4_q;
    assign id_valid   = id_valid_q;
    assign if_ready   = if_ready_q;

`ifdef PIPE_IF2ID_STATCNT_EN
    logic [31:0] stallcnt_q, stallcnt_d;

    // A flush in the same cycle does not hide the stall, so it still counts.
    // The count saturates instead of wrapping.
    always_comb begin
        stallcnt_d = stallcnt_q;
        if (id_valid_q && id_stall && (stallcnt_q != 32'hFFFF_FFFF)) begin
            stallcnt_d = stallcnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stallcnt_q <= 32'h0;
        end else begin
            stallcnt_q <= stallcnt_d;
        end
    end

    assign stallcnt = stallcnt_q;
`endif

endmodule

// File: doc/pipe_if2id.md
# pipe_if2id

Registered IF/ID pipeline boundary for the MIPS core. It carries the fetched instruction word and its PC+4 from the fetch stage to decode. It holds its contents when decode stalls and converts them to a NOP bubble on a control-flow flush. A one-entry skid buffer absorbs the word that instruction memory returns in the same cycle a stall begins, so fetch never drops a word.

## Interface
Parameters:
- `NOP_INSTR`, default 32'h0000_0000 — word driven on `id_instr` whenever the stage holds no valid instruction (`sll $0,$0,0`).

Ports:
- `clk` input 1 — single clock; all state updates on the rising edge.
- `reset` input 1 — synchronous, active-low; reset is applied when `reset`=0 at a rising edge.
- `if_instr` input 32 — fetched instruction word.
- `if_pcplus4` input 32 — PC+4 of `if_instr`.
- `if_valid` input 1 — `if_instr` and `if_pcplus4` are valid this cycle.
- `if_ready` output 1 — registered; the stage accepts a word this cycle. Fetch must not advance the PC while this is 0.
- `id_stall` input 1 — decode cannot consume the current word (hazard unit).
- `flush` input 1 — squash all held and incoming words (taken branch or jump resolved).
- `id_instr` output 32 — registered instruction word to decode.
- `id_pcplus4` output 32 — registered PC+4 to decode.
- `id_valid` output 1 — registered; `id_instr` is a real instruction.
- `stallcnt` output 32 — present only with `PIPE_IF2ID_STATCNT_EN`; see Configuration.

## Operation
- accept = `if_valid` && `if_ready`.
- consume = `id_valid` && !`id_stall`.
- Storage is a main register (drives the `id_*` outputs) and a skid register. A state register tracks occupancy with three states: EMPTY, FULL, SKID.
- EMPTY:
  - accept → FULL, main ← input.
  - no accept → stay EMPTY.
- FULL:
  - consume && accept → FULL, main ← input.
  - consume && !accept → EMPTY.
  - !consume && accept → SKID, skid ← input.
  - !consume && !accept → FULL, hold.
- SKID (`if_ready`=0, so no accept is possible):
  - consume → FULL, main ← skid.
  - no consume → hold both entries.
- `if_ready` is registered as (next state != SKID).
- `flush` has the highest priority after reset. At the edge:
  - state ← EMPTY.
  - Any word accepted in the same cycle is discarded.
  - `id_valid` ← 0, `id_instr` ← `NOP_INSTR`, `id_pcplus4` ← 0, `if_ready` ← 1.
- Whenever `id_valid`=0, `id_instr`=`NOP_INSTR` and `id_pcplus4`=0. Decode may therefore treat the outputs as a bubble without checking `id_valid`.
- `id_stall` while EMPTY has no effect.
- The skid contents are don't-care when not in SKID. The skid register is never visible on the outputs.
- Word order is strictly preserved: a skid word always leaves before any later word is accepted.

## Timing
- Reset (`reset`=0 at an edge) sets: state EMPTY, `id_valid`=0, `id_instr`=`NOP_INSTR`, `id_pcplus4`=0, `if_ready`=1, `stallcnt`=0.
- Reset takes priority over `flush` and all other inputs. Reset mid-stall discards both entries.
- Latency: a word accepted at edge N appears on `id_*` with `id_valid`=1 after edge N.
- Throughput: one word per cycle while `id_stall`=0.
- Skid path:
  - `if_ready` falls after the edge at which SKID is entered.
  - After the first edge with consume, the skid word is on `id_*` and `if_ready`=1.
- Simultaneous `flush` and `id_stall`: flush wins, and the stage is EMPTY after the edge.
- Simultaneous `flush` and accept: the word is dropped, and fetch treats it as consumed.

## Configuration
- `PIPE_IF2ID_STATCNT_EN` defined:
  - Adds the `stallcnt` port: a 32-bit counter that increments at each edge where `id_valid`=1 and `id_stall`=1.
  - The counter saturates at 32'hFFFF_FFFF.
  - It is cleared only by reset; `flush` does not clear it.
- Macro undefined: the `stallcnt` port and counter logic are absent, and all other behaviour is identical.

## Test plan
- Reset then streaming: release reset, present words 0x20080001, 0x20090002, 0x200A0003 with PC+4 0x4, 0x8, 0xC on consecutive cycles, `id_stall`=0 → `id_*` shows each word one cycle later, `id_valid`=1, `if_ready` stays 1.
- Stall with skid: word A in main, assert `id_stall` while word B is accepted → `if_ready`=0 next cycle and A is held. Hold the stall 3 cycles → A is stable. Release → B is on `id_*` one cycle later and `if_ready`=1.
- Flush in SKID: with A in main and B in skid, assert `flush` for one cycle → `id_valid`=0, `id_instr`=0x00000000, `if_ready`=1, and B never appears.
- Flush plus accept: EMPTY, `flush`=1 with `if_valid`=1 and word 0x08000010 → after the edge `id_valid`=0. The next accepted word appears normally.
- Reset mid-operation: SKID state, drive `reset`=0 for one edge → all outputs take their reset values, even with `id_stall`=1 and `if_valid`=1.
- With `PIPE_IF2ID_STATCNT_EN`: hold `id_stall`=1 for 5 cycles with `id_valid`=1, then 2 cycles while EMPTY → `stallcnt`=5. Apply `flush` → `stallcnt` remains 5.
